// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    HOLD      = 3'd0,
    LOCK_WAIT = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SWRST     = 3'd4
  } seq_state_t;

  // Largest of three values. The shared counter must hold every terminal count.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control and status bundle between the reset sequencer and its host.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4
);

  logic                   srst_n;
  logic                   pll_locked;
  logic                   sw_rst_req;
  logic [NUM_STAGES-1:0]  stage_rst_n;
  logic                   seq_done;
  logic                   busy;
  logic [SEQ_STATE_W-1:0] seq_state;

  modport master (
    output srst_n, pll_locked, sw_rst_req,
    input  stage_rst_n, seq_done, busy, seq_state
  );

  modport slave (
    input  srst_n, pll_locked, sw_rst_req,
    output stage_rst_n, seq_done, busy, seq_state
  );

endinterface

// File: rtl/reset_sequencer_bit_sync.sv
// Two-flop single-bit synchronizer with asynchronous active-low clear.
module bit_sync (
  input  logic clk,
  input  logic arst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in order once the PLL is stably locked.
//
// state     | meaning
// HOLD      | srst_n low, every domain held in reset
// LOCK_WAIT | waiting for LOCK_FILTER consecutive cycles of lock
// RELEASE   | releasing one domain every STAGE_DELAY cycles, bit 0 first
// RUN       | all domains released, seq_done high
// SWRST     | software reset, all domains low for SW_RST_CYCLES
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int STAGE_DELAY   = 16,
  parameter int LOCK_FILTER   = 8,
  parameter int SW_RST_CYCLES = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  reset_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(max3(LOCK_FILTER, STAGE_DELAY, SW_RST_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] LF_TC    = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] SD_TC    = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] SW_TC    = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  lock_s;

  bit_sync u_lock_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d_i    (bus.pll_locked),
    .q_o    (lock_s)
  );

  // State, counter, index and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: srst_n beats lock loss, which beats normal sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!bus.srst_n) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (!lock_s && (state_q == RELEASE || state_q == RUN || state_q == SWRST)) begin
      state_d = LOCK_WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
        end
        LOCK_WAIT: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LF_TC) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == SD_TC) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (bus.sw_rst_req) begin
            state_d = SWRST;
            cnt_d   = '0;
          end
        end
        SWRST: begin
          if (cnt_q == SW_TC) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs: stages stay high only while heading into RELEASE/RUN, so every
  // exit path clears them; a release step adds the bit at idx on top.
  always_comb begin
    stage_d = '0;
    if (state_d == RELEASE || state_d == RUN) begin
      stage_d = stage_q;
      if (state_q == RELEASE && cnt_q == SD_TC) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (IDX_W'(i) == idx_q) stage_d[i] = 1'b1;
        end
      end
    end
    done_d = (state_d == RUN);
    busy_d = (state_d != RUN);
  end

  assign bus.stage_rst_n = stage_q;
  assign bus.seq_done    = done_q;
  assign bus.busy        = busy_q;
  assign bus.seq_state   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a time-based reference model.
module tb_reset_sequencer;

  localparam int NS  = 4;
  localparam int SD  = 16;
  localparam int LF  = 8;
  localparam int SWC = 32;

  localparam int M_HOLD = 0;
  localparam int M_WAIT = 1;
  localparam int M_REL  = 2;
  localparam int M_RUN  = 3;
  localparam int M_SW   = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES    (NS),
    .STAGE_DELAY   (SD),
    .LOCK_FILTER   (LF),
    .SW_RST_CYCLES (SWC)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: mode plus elapsed edges in that mode; stage count follows from time.
  logic [31:0] m_mode = M_HOLD;
  logic [31:0] m_t    = 0;
  logic [1:0]  m_sync = 2'b00;

  function automatic logic [63:0] model_step(input int mode, input int t, input logic ls,
                                             input logic srst, input logic sw);
    int nm = mode;
    int nt = t;
    if (!srst) begin
      nm = M_HOLD; nt = 0;
    end else if (!ls && (mode == M_REL || mode == M_RUN || mode == M_SW)) begin
      nm = M_WAIT; nt = 0;
    end else begin
      case (mode)
        M_HOLD: begin nm = M_WAIT; nt = 0; end
        M_WAIT: begin
          if (ls) begin
            nt = t + 1;
            if (nt == LF) begin nm = M_REL; nt = 0; end
          end else nt = 0;
        end
        M_REL: begin
          nt = t + 1;
          if (nt == SD * NS) nm = M_RUN;
        end
        M_RUN: if (sw) begin nm = M_SW; nt = 0; end
        M_SW: begin
          nt = t + 1;
          if (nt == SWC) begin nm = M_REL; nt = 0; end
        end
        default: ;
      endcase
    end
    return {32'(nm), 32'(nt)};
  endfunction

  function automatic logic [NS-1:0] exp_stage(input int mode, input int t);
    logic [NS-1:0] v;
    int n;
    v = '0;
    if (mode == M_RUN) n = NS;
    else if (mode == M_REL) n = (t / SD > NS) ? NS : t / SD;
    else n = 0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_mode <= M_HOLD;
      m_t    <= 0;
      m_sync <= 2'b00;
    end else begin
      {m_mode, m_t} <= model_step(int'(m_mode), int'(m_t), m_sync[1], bus.srst_n, bus.sw_rst_req);
      m_sync <= {m_sync[0], bus.pll_locked};
    end
  end

  // Per-cycle comparison against the model plus the standing invariants.
  always @(negedge clk) begin
    check("stage_rst_n", 32'(bus.stage_rst_n), 32'(exp_stage(int'(m_mode), int'(m_t))));
    check("seq_done", 32'(bus.seq_done), 32'(m_mode == M_RUN));
    check("busy", 32'(bus.busy), 32'(m_mode != M_RUN));
    check("seq_state", 32'(bus.seq_state), 32'(m_mode[2:0]));
    check("thermometer", 32'((bus.stage_rst_n & (bus.stage_rst_n + 1'b1)) == '0), 32'd1);
    check("busy_vs_done", 32'(bus.busy), 32'(!bus.seq_done));
    if (bus.seq_state == 3'd0 || bus.seq_state == 3'd1)
      check("no_stage_in_hold_wait", 32'(bus.stage_rst_n), 32'd0);
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.srst_n     = 1'b0;
    bus.pll_locked = 1'b1;
    bus.sw_rst_req = 1'b0;
    run(2);
    check("rst_stage", 32'(bus.stage_rst_n), 32'h0);
    check("rst_done", 32'(bus.seq_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_state", 32'(bus.seq_state), 32'd0);
    arst_n = 1'b1;
    run(4);

    // Clean power-up: srst_n sampled high at E0 with lock already settled.
    bus.srst_n = 1'b1;
    run(1);
    check("e0_state", 32'(bus.seq_state), 32'd1);
    run(23);
    check("e0p23_stage", 32'(bus.stage_rst_n), 32'h0);
    check("e0p23_state", 32'(bus.seq_state), 32'd2);
    run(1);
    check("e0p24_stage", 32'(bus.stage_rst_n), 32'h1);
    run(16);
    check("e0p40_stage", 32'(bus.stage_rst_n), 32'h3);
    run(16);
    check("e0p56_stage", 32'(bus.stage_rst_n), 32'h7);
    run(15);
    check("e0p71_done", 32'(bus.seq_done), 32'd0);
    run(1);
    check("e0p72_stage", 32'(bus.stage_rst_n), 32'hF);
    check("e0p72_done", 32'(bus.seq_done), 32'd1);
    check("e0p72_busy", 32'(bus.busy), 32'd0);

    // Software reset from RUN.
    bus.sw_rst_req = 1'b1;
    run(1);
    bus.sw_rst_req = 1'b0;
    check("sw_stage", 32'(bus.stage_rst_n), 32'h0);
    check("sw_busy", 32'(bus.busy), 32'd1);
    check("sw_state", 32'(bus.seq_state), 32'd4);
    run(31);
    check("sw31_state", 32'(bus.seq_state), 32'd4);
    run(1);
    check("sw32_state", 32'(bus.seq_state), 32'd2);
    run(15);
    check("sw47_stage", 32'(bus.stage_rst_n), 32'h0);
    run(1);
    check("sw48_stage", 32'(bus.stage_rst_n), 32'h1);
    run(16);
    check("sw64_stage", 32'(bus.stage_rst_n), 32'h3);

    // Lock loss mid-release.
    bus.pll_locked = 1'b0;
    run(2);
    check("ll2_stage", 32'(bus.stage_rst_n), 32'h3);
    run(1);
    check("ll3_stage", 32'(bus.stage_rst_n), 32'h0);
    check("ll3_state", 32'(bus.seq_state), 32'd1);
    bus.pll_locked = 1'b1;
    run(25);
    check("ll28_stage", 32'(bus.stage_rst_n), 32'h0);
    run(1);
    check("ll29_stage", 32'(bus.stage_rst_n), 32'h1);
    run(48);
    check("ll77_stage", 32'(bus.stage_rst_n), 32'hF);
    check("ll77_done", 32'(bus.seq_done), 32'd1);

    // srst_n low together with sw_rst_req in RUN: HOLD wins.
    bus.srst_n     = 1'b0;
    bus.sw_rst_req = 1'b1;
    run(1);
    bus.sw_rst_req = 1'b0;
    check("srst_state", 32'(bus.seq_state), 32'd0);
    check("srst_stage", 32'(bus.stage_rst_n), 32'h0);
    check("srst_done", 32'(bus.seq_done), 32'd0);
    bus.pll_locked = 1'b0;
    run(3);
    bus.srst_n = 1'b1;
    run(1);
    bus.sw_rst_req = 1'b1;
    run(1);
    bus.sw_rst_req = 1'b0;
    check("sw_in_wait_state", 32'(bus.seq_state), 32'd1);
    run(4);

    // Lock glitch: 5 cycles high, 1 low, then high; the filter must restart.
    bus.pll_locked = 1'b1;
    run(5);
    bus.pll_locked = 1'b0;
    run(1);
    bus.pll_locked = 1'b1;
    run(9);
    check("glitch15_state", 32'(bus.seq_state), 32'd1);
    run(1);
    check("glitch16_state", 32'(bus.seq_state), 32'd2);
    run(15);
    check("glitch31_stage", 32'(bus.stage_rst_n), 32'h0);
    run(1);
    check("glitch32_stage", 32'(bus.stage_rst_n), 32'h1);

    // Asynchronous reset mid-release acts without a clock edge.
    run(5);
    arst_n = 1'b0;
    #1;
    check("arst_stage", 32'(bus.stage_rst_n), 32'h0);
    check("arst_done", 32'(bus.seq_done), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd1);
    check("arst_state", 32'(bus.seq_state), 32'd0);
    run(2);
    arst_n = 1'b1;
    run(100);
    check("final_stage", 32'(bus.stage_rst_n), 32'hF);
    check("final_done", 32'(bus.seq_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
